// File: rtl/i2c_rb_master_if.sv
// Request/response handshake and open-drain I2C pad signals for i2c_rb_master.
// The master modport is the controller's view; the slave modport is the
// requester/pad-side view (request inputs driven, status and drives observed).
interface i2c_rb_master_if;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_out;
    logic       scl_in;
    logic       sda_out;
    logic       sda_in;

    modport master (
        input  start, rw, dev_addr, reg_addr, wdata, scl_in, sda_in,
        output rdata, busy, done, ack_err, scl_out, sda_out
    );

    modport slave (
        output start, rw, dev_addr, reg_addr, wdata, scl_in, sda_in,
        input  rdata, busy, done, ack_err, scl_out, sda_out
    );
endinterface

// File: rtl/i2c_rb_master.sv
// Single-register I2C master: one register write or one register read
// (with repeated START) per start request. Each bit is four quarters of
// CLK_DIV+1 clk; SCL low in Q0/Q1, released in Q2/Q3, SDA changes at Q0 start,
// SDA sampled on the last cycle of Q2. scl_out/sda_out are open-drain
// enables: 0 pulls the line low, 1 releases it.
//
// state  | meaning
// IDLE   | lines released, waiting for start
// START  | START (or the START half of a repeated START), 4 quarters
// TXBYTE | shifting out shreg MSB first, 8 bits
// RXACK  | target ACK bit; NACK aborts to STOP
// RSTART | release SDA, then SCL, before the repeated START
// RXBYTE | shifting in the read data byte, 8 bits
// TXNACK | master NACK after the read byte (SDA released)
// STOP   | SDA low/SCL low, SCL release, SDA release (3 quarters)
// DONE   | one-cycle done pulse, rdata updated on the way in
module i2c_rb_master #(
    parameter int unsigned CLK_DIV = 63
) (
    input logic               clk,
    input logic               resetb,
    i2c_rb_master_if.master   bus
);

    localparam int QW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam logic [QW-1:0] QRELOAD = QW'(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, TXNACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ack_err_q, ack_err_d;

    logic scl_drv;
    logic sda_drv;
    logic stretch;
    logic q_end;

    // Line drives decoded from state and quarter; everything decoded is registered.
    always_comb begin
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        case (state_q)
            START: begin
                scl_drv = (quarter_q != 2'd3);
                sda_drv = (quarter_q < 2'd2);
            end
            TXBYTE: begin
                scl_drv = quarter_q[1];
                sda_drv = shreg_q[7];
            end
            RXACK, RXBYTE, TXNACK: begin
                scl_drv = quarter_q[1];
                sda_drv = 1'b1;
            end
            RSTART: begin
                scl_drv = (quarter_q != 2'd0);
                sda_drv = 1'b1;
            end
            STOP: begin
                scl_drv = (quarter_q != 2'd0);
                sda_drv = (quarter_q == 2'd2);
            end
            default: begin
                scl_drv = 1'b1;
                sda_drv = 1'b1;
            end
        endcase
    end

    // A released SCL still held low by a target freezes the quarter timer.
    assign stretch = scl_drv & ~bus.scl_in;
    assign q_end   = (qcnt_q == '0) && !stretch;

    // Next-state, quarter timer, shift register and status updates.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bitcnt_d  = bitcnt_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;

        if (state_q != IDLE && state_q != DONE && !stretch) begin
            qcnt_d = (qcnt_q == '0) ? QRELOAD : qcnt_q - 1'b1;
        end
        if (q_end) begin
            quarter_d = quarter_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rw_d      = bus.rw;
                    dev_d     = bus.dev_addr;
                    reg_d     = bus.reg_addr;
                    wdata_d   = bus.wdata;
                    shreg_d   = {bus.dev_addr, 1'b0};
                    ack_err_d = 1'b0;
                    byte_d    = 2'd0;
                    bitcnt_d  = 3'd0;
                    qcnt_d    = QRELOAD;
                    quarter_d = 2'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (q_end && quarter_q == 2'd3) begin
                    bitcnt_d = 3'd0;
                    state_d  = TXBYTE;
                end
            end
            TXBYTE: begin
                if (q_end && quarter_q == 2'd3) begin
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RXACK;
                    end
                end
            end
            RXACK: begin
                if (q_end && quarter_q == 2'd2 && bus.sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (q_end && quarter_q == 2'd3) begin
                    bitcnt_d = 3'd0;
                    if (ack_err_q) begin
                        state_d = STOP;
                    end else begin
                        case (byte_q)
                            2'd0: begin
                                shreg_d = reg_q;
                                byte_d  = 2'd1;
                                state_d = TXBYTE;
                            end
                            2'd1: begin
                                byte_d = 2'd2;
                                if (rw_q) begin
                                    shreg_d = {dev_q, 1'b1};
                                    state_d = RSTART;
                                end else begin
                                    shreg_d = wdata_q;
                                    state_d = TXBYTE;
                                end
                            end
                            default: begin
                                state_d = rw_q ? RXBYTE : STOP;
                            end
                        endcase
                    end
                end
            end
            RSTART: begin
                if (q_end && quarter_q == 2'd1) begin
                    quarter_d = 2'd0;
                    state_d   = START;
                end
            end
            RXBYTE: begin
                if (q_end && quarter_q == 2'd2) begin
                    shreg_d = {shreg_q[6:0], bus.sda_in};
                end
                if (q_end && quarter_q == 2'd3) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = TXNACK;
                    end
                end
            end
            TXNACK: begin
                if (q_end && quarter_q == 2'd3) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (q_end && quarter_q == 2'd2) begin
                    quarter_d = 2'd0;
                    state_d   = DONE;
                    // shreg only holds received data after a clean read.
                    if (rw_q && !ack_err_q) begin
                        rdata_d = shreg_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bitcnt_q  <= 3'd0;
            byte_q    <= 2'd0;
            shreg_q   <= 8'd0;
            rw_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bitcnt_q  <= bitcnt_d;
            byte_q    <= byte_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.scl_out = scl_drv;
    assign bus.sda_out = sda_drv;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.rdata   = rdata_q;
    assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_rb_master.sv
// Bench for i2c_rb_master: a bus-level target model decodes START/STOP,
// bytes and ACKs from the open-drain lines and checks each event against a
// queue of expected events; a done monitor checks completion status.
module tb_i2c_rb_master;

    localparam int CLK_DIV = 3;
    localparam int BIT_CLK = 4 * (CLK_DIV + 1);
    localparam int STRETCH = 50;
    localparam int EV_START = 'h300;
    localparam int EV_STOP  = 'h400;
    localparam int EV_MNACK = 'h201;

    typedef struct {
        int ack;
        int rdata;
        int pulses;
    } done_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    i2c_rb_master_if bus_if();

    int checks = 0;
    int errors = 0;
    int    exp_ev[$];
    done_t exp_done[$];

    // target model state
    logic       slave_sda = 1'b1;
    bit         slave_present = 1'b1;
    bit         stretch_en = 1'b0;
    logic [7:0] rd_val = 8'h00;
    int         hold_cnt = 0;
    int         sl_bitn = 0;
    int         sl_bytn = 0;
    int         pulses = 0;
    bit         rd_mode = 0;
    bit         rd_phase = 0;
    bit         in_txn = 0;
    bit         stop_seen = 0;
    bit         pvalid = 0;
    logic       cur_bit = 1'b1;
    logic [7:0] sh = 8'h00;
    bit         p_scl = 1'b1;
    bit         p_sda = 1'b1;
    bit         p_sclo = 1'b1;
    int         cyc = 0;
    int         last_fall = 0;
    bit         busy_chk_pend = 0;

    always #5 clk = ~clk;

    assign bus_if.scl_in = bus_if.scl_out & (hold_cnt == 0);
    assign bus_if.sda_in = bus_if.sda_out & slave_sda;

    i2c_rb_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_if.master)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic ev(input int v);
        if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_event got %0h exp none", v);
        end else begin
            chk("bus_event", v, exp_ev.pop_front());
        end
    endtask

    // Bus decoder and target: START/STOP, bit pulses, ACK and read-data drive, stretching.
    always @(negedge clk) begin : target_model
        logic scl_b;
        logic sda_b;
        int   per;
        cyc++;
        if (!resetb) begin
            in_txn   = 0;
            hold_cnt = 0;
            slave_sda = 1'b1;
            pvalid   = 0;
        end
        if (bus_if.scl_out && !p_sclo && stretch_en && sl_bytn == 1 && sl_bitn == 3)
            hold_cnt = STRETCH;
        else if (hold_cnt > 0)
            hold_cnt--;
        scl_b = bus_if.scl_out && (hold_cnt == 0);
        sda_b = bus_if.sda_out && slave_sda;

        if (p_scl && scl_b && p_sda && !sda_b) begin
            ev(EV_START);
            if (!in_txn) pulses = 0;
            in_txn = 1; stop_seen = 0; pvalid = 0;
            sl_bitn = 0; sl_bytn = 0; rd_mode = 0; rd_phase = 0; slave_sda = 1'b1;
        end else if (p_scl && scl_b && !p_sda && sda_b) begin
            ev(EV_STOP);
            in_txn = 0; stop_seen = 1; pvalid = 0;
        end else if (!p_scl && scl_b) begin
            pvalid  = 1;
            cur_bit = sda_b;
        end else if (p_scl && !scl_b) begin
            per = cyc - last_fall;
            last_fall = cyc;
            if (pvalid) begin
                pulses++;
                if (stretch_en && sl_bytn == 1 && sl_bitn == 3) chk("stretched_bit_period", per, BIT_CLK + STRETCH);
                if (stretch_en && sl_bytn == 1 && sl_bitn == 2) chk("normal_bit_period", per, BIT_CLK);
                if (sl_bitn < 8) begin
                    sh = {sh[6:0], cur_bit};
                    sl_bitn++;
                    if (sl_bitn == 8) begin
                        ev(int'(sh));
                        if (rd_phase) begin
                            slave_sda = 1'b1;
                        end else begin
                            if (sl_bytn == 0) rd_mode = sh[0];
                            slave_sda = slave_present ? 1'b0 : 1'b1;
                        end
                    end else if (rd_phase) begin
                        slave_sda = rd_val[7 - sl_bitn];
                    end
                end else begin
                    if (rd_phase) ev('h200 | int'(cur_bit));
                    sl_bitn = 0;
                    sl_bytn++;
                    slave_sda = 1'b1;
                    rd_phase = 0;
                    if (rd_mode && sl_bytn == 1) begin
                        rd_phase  = 1;
                        slave_sda = rd_val[7];
                    end
                end
            end
            pvalid = 0;
        end
        p_scl  = scl_b;
        p_sda  = sda_b;
        p_sclo = bus_if.scl_out;
    end

    // Completion monitor: status at the done pulse, busy low the cycle after.
    always @(negedge clk) begin : done_monitor
        done_t e;
        if (busy_chk_pend) begin
            chk("busy_after_done", int'(bus_if.busy), 0);
            busy_chk_pend = 0;
        end
        if (resetb && bus_if.done) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got 1 exp 0");
            end else begin
                e = exp_done.pop_front();
                chk("done_ack_err", int'(bus_if.ack_err), e.ack);
                chk("done_rdata", int'(bus_if.rdata), e.rdata);
                chk("done_scl_pulses", pulses, e.pulses);
                chk("done_stop_seen", int'(stop_seen), 1);
            end
            busy_chk_pend = 1;
        end
    end

    task automatic push_done(input int ack, input int rd, input int np);
        done_t d;
        d.ack = ack; d.rdata = rd; d.pulses = np;
        exp_done.push_back(d);
    endtask

    task automatic exp_write(input int a, input int ra, input int wd, input int rd_now);
        exp_ev.push_back(EV_START);
        exp_ev.push_back(a);
        exp_ev.push_back(ra);
        exp_ev.push_back(wd);
        exp_ev.push_back(EV_STOP);
        push_done(0, rd_now, 27);
    endtask

    task automatic exp_read(input int aw, input int ra, input int ar, input int val);
        exp_ev.push_back(EV_START);
        exp_ev.push_back(aw);
        exp_ev.push_back(ra);
        exp_ev.push_back(EV_START);
        exp_ev.push_back(ar);
        exp_ev.push_back(val);
        exp_ev.push_back(EV_MNACK);
        exp_ev.push_back(EV_STOP);
        push_done(0, val, 36);
    endtask

    task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
        bus_if.rw = r;
        bus_if.dev_addr = d;
        bus_if.reg_addr = ra;
        bus_if.wdata = wd;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("busy_after_accept", int'(bus_if.busy), 1);
        bus_if.rw = ~r;
        bus_if.dev_addr = 7'h7F;
        bus_if.reg_addr = 8'hFF;
        bus_if.wdata = 8'h00;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus_if.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", int'(bus_if.done), 1);
    endtask

    initial begin
        int n;
        bus_if.start = 1'b0;
        bus_if.rw = 1'b0;
        bus_if.dev_addr = 7'h00;
        bus_if.reg_addr = 8'h00;
        bus_if.wdata = 8'h00;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl_out", int'(bus_if.scl_out), 1);
        chk("rst_sda_out", int'(bus_if.sda_out), 1);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_done", int'(bus_if.done), 0);
        chk("rst_ack_err", int'(bus_if.ack_err), 0);
        chk("rst_rdata", int'(bus_if.rdata), 0);
        resetb = 1'b1;
        repeat (3) @(negedge clk);

        // register write with ACKing target
        exp_write('h54, 'h05, 'hC3, 'h00);
        issue(1'b0, 7'h2A, 8'h05, 8'hC3);
        wait_done(3000);
        repeat (5) @(negedge clk);

        // register read returning 0xA5
        rd_val = 8'hA5;
        exp_read('h54, 'h10, 'h55, 'hA5);
        issue(1'b1, 7'h2A, 8'h10, 8'h00);
        wait_done(3000);
        repeat (5) @(negedge clk);

        // no target present: NACK on address, rdata kept
        slave_present = 1'b0;
        exp_ev.push_back(EV_START);
        exp_ev.push_back('h54);
        exp_ev.push_back(EV_STOP);
        push_done(1, 'hA5, 9);
        issue(1'b1, 7'h2A, 8'h33, 8'h00);
        wait_done(3000);
        slave_present = 1'b1;
        repeat (5) @(negedge clk);

        // clock stretching on bit 3 of the register byte; ack_err clears on accept
        stretch_en = 1'b1;
        exp_write('h54, 'h5A, 'h0F, 'hA5);
        issue(1'b0, 7'h2A, 8'h5A, 8'h0F);
        wait_done(3000);
        stretch_en = 1'b0;
        repeat (5) @(negedge clk);

        // start while busy is ignored; start held through DONE launches the next one
        exp_write('h54, 'h01, 'h11, 'hA5);
        issue(1'b0, 7'h2A, 8'h01, 8'h11);
        repeat (20) @(negedge clk);
        bus_if.rw = 1'b1;
        bus_if.dev_addr = 7'h15;
        bus_if.reg_addr = 8'h99;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(3000);
        exp_write('h54, 'h02, 'h22, 'hA5);
        bus_if.rw = 1'b0;
        bus_if.dev_addr = 7'h2A;
        bus_if.reg_addr = 8'h02;
        bus_if.wdata = 8'h22;
        bus_if.start = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.start = 1'b0;
        chk("busy_after_held_start", int'(bus_if.busy), 1);
        wait_done(3000);
        repeat (5) @(negedge clk);

        // reset in the middle of the data byte
        exp_ev.push_back(EV_START);
        exp_ev.push_back('h54);
        exp_ev.push_back('h05);
        issue(1'b0, 7'h2A, 8'h05, 8'hC3);
        n = 0;
        while (!(sl_bytn == 2 && sl_bitn == 4 && !bus_if.scl_out) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_data_bit4", int'(sl_bytn == 2 && sl_bitn == 4), 1);
        resetb = 1'b0;
        @(negedge clk);
        chk("midrst_scl_out", int'(bus_if.scl_out), 1);
        chk("midrst_sda_out", int'(bus_if.sda_out), 1);
        chk("midrst_busy", int'(bus_if.busy), 0);
        chk("midrst_done", int'(bus_if.done), 0);
        repeat (2) @(negedge clk);
        chk("midrst_rdata", int'(bus_if.rdata), 0);
        resetb = 1'b1;
        repeat (30) @(negedge clk);

        // normal write after the abort
        exp_write('h54, 'h05, 'hC3, 'h00);
        issue(1'b0, 7'h2A, 8'h05, 8'hC3);
        wait_done(3000);
        repeat (20) @(negedge clk);

        chk("events_left", exp_ev.size(), 0);
        chk("dones_left", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
